// File: rtl/handshake_constant_seq_pkg.sv
// rtl/handshake_constant_seq_pkg.sv - shared constants and helpers for the constant-sequence handshake source
//
// Contents:
//   HS_CONST_SEQ_MAX_DEPTH - largest table depth the block is built for
//   clog2_min1(n)          - ceil(log2(n)), never less than 1 (index width)
package handshake_constant_seq_pkg;

  localparam int HS_CONST_SEQ_MAX_DEPTH = 256;

  // Bounded loop so the function stays elaboration-friendly for any tool.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/handshake_skid_buf.sv
// rtl/handshake_skid_buf.sv - two-entry skid buffer with a registered upstream ready
//
// Ports:
//   clk, rst                     rising-edge clock, asynchronous active-low reset
//   in_tdata/in_tvalid/in_tready upstream stream; in_tready comes straight from a flop
//   out_tdata/out_tvalid/out_tready downstream stream; out_tdata is registered
module handshake_skid_buf
  import handshake_constant_seq_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready
);

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_v;
  logic             skid_v;
  logic             push;
  logic             pop;

  // The skid slot only fills while the main slot is full, so "skid occupied"
  // is exactly "both entries full" and ready can be taken from that flop.
  assign in_tready  = !skid_v;
  assign push       = in_tvalid && !skid_v;
  assign pop        = main_v && out_tready;
  assign out_tdata  = main_q;
  assign out_tvalid = main_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || pop) begin
      // Main slot frees up: refill from the skid slot first to keep order.
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= push;
        if (push) main_q <= in_tdata;
      end
    end else if (push) begin
      skid_q <= in_tdata;
      skid_v <= 1'b1;
    end
  end

endmodule

// File: rtl/handshake_constant_seq.sv
// rtl/handshake_constant_seq.sv - emits one table constant per accepted control token, wrapping at DEPTH
//
// Build option: HANDSHAKE_CONSTANT_SEQ_SKID_EN selects a two-entry skid buffer
// with registered ctrl_ready; otherwise a single output register is used.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   ctrl_valid/ctrl_ready    control token handshake
//   rewind                   restart the sequence at entry 0
//   outs/outs_last           current constant and "entry DEPTH-1" marker
//   outs_valid/outs_ready    output handshake
module handshake_constant_seq
  import handshake_constant_seq_pkg::*;
#(
  parameter int                          DATA_WIDTH = 32,
  parameter int                          DEPTH      = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] TABLE      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  input  logic                  rewind,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_last,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int               IDX_W    = clog2_min1(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      sel_idx;
  logic [DATA_WIDTH-1:0] tok_data;
  logic                  tok_last;
  logic                  accept;

  // A rewind coinciding with an accept makes that token use entry 0.
  assign sel_idx  = rewind ? '0 : idx;
  assign tok_last = (sel_idx == LAST_IDX);
  assign accept   = ctrl_valid && ctrl_ready;

  always_comb begin
    tok_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_idx == IDX_W'(i)) tok_data = TABLE[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Explicit wrap keeps non-power-of-two depths legal; DEPTH=1 always sees
  // tok_last and therefore holds idx at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (accept) begin
      idx <= tok_last ? '0 : sel_idx + 1'b1;
    end else if (rewind) begin
      idx <= '0;
    end
  end

`ifdef HANDSHAKE_CONSTANT_SEQ_SKID_EN
  logic [DATA_WIDTH:0] buf_tdata;

  handshake_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_tdata  ({tok_last, tok_data}),
    .in_tvalid (ctrl_valid),
    .in_tready (ctrl_ready),
    .out_tdata (buf_tdata),
    .out_tvalid(outs_valid),
    .out_tready(outs_ready)
  );

  assign {outs_last, outs} = buf_tdata;
`else
  logic [DATA_WIDTH:0] out_q;
  logic                out_v;

  assign ctrl_ready        = !out_v || outs_ready;
  assign outs_valid        = out_v;
  assign {outs_last, outs} = out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      out_v <= 1'b0;
    end else if (accept) begin
      out_q <= {tok_last, tok_data};
      out_v <= 1'b1;
    end else if (outs_ready) begin
      out_v <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_constant_seq.sv
// tb/tb_handshake_constant_seq.sv - self-checking bench for handshake_constant_seq
module tb_handshake_constant_seq;

`ifdef HANDSHAKE_CONSTANT_SEQ_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        c_valid [3];
  logic        c_ready [3];
  logic        rw      [3];
  logic [31:0] o_data  [3];
  logic        o_last  [3];
  logic        o_valid [3];
  logic        o_ready [3];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          d   [3];
  int          pos [3];
  logic [31:0] tbl [3][5];
  logic [32:0] q[$];

  always #5 clk = ~clk;

  handshake_constant_seq #(.DATA_WIDTH(32), .DEPTH(3),
    .TABLE({32'h33, 32'h22, 32'h11})) u_d3 (
    .clk(clk), .rst(rst), .ctrl_valid(c_valid[0]), .ctrl_ready(c_ready[0]),
    .rewind(rw[0]), .outs(o_data[0]), .outs_last(o_last[0]),
    .outs_valid(o_valid[0]), .outs_ready(o_ready[0]));

  handshake_constant_seq #(.DATA_WIDTH(32), .DEPTH(1),
    .TABLE(32'hDEADBEEF)) u_d1 (
    .clk(clk), .rst(rst), .ctrl_valid(c_valid[1]), .ctrl_ready(c_ready[1]),
    .rewind(rw[1]), .outs(o_data[1]), .outs_last(o_last[1]),
    .outs_valid(o_valid[1]), .outs_ready(o_ready[1]));

  handshake_constant_seq #(.DATA_WIDTH(32), .DEPTH(5),
    .TABLE({32'h55550004, 32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000})) u_d5 (
    .clk(clk), .rst(rst), .ctrl_valid(c_valid[2]), .ctrl_ready(c_ready[2]),
    .rewind(rw[2]), .outs(o_data[2]), .outs_last(o_last[2]),
    .outs_valid(o_valid[2]), .outs_ready(o_ready[2]));

  // Reference model: the n-th token since reset/rewind carries entry n mod DEPTH.
  // Called after inputs are driven for the cycle; observes the pre-edge handshake.
  task automatic sample(input int k, output logic acc, output logic em, output logic have,
                        output logic [32:0] exp, output logic [32:0] got);
    int p;
    #1;
    acc  = c_valid[k] & c_ready[k];
    em   = o_valid[k] & o_ready[k];
    got  = {o_last[k], o_data[k]};
    have = (q.size() != 0);
    exp  = '0;
    if (em && have) exp = q.pop_front();
    if (acc) begin
      p = rw[k] ? 0 : pos[k];
      q.push_back({(p == d[k] - 1), tbl[k][p]});
      pos[k] = (p + 1) % d[k];
    end else if (rw[k]) begin
      pos[k] = 0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (o_valid[k] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", k, o_valid[k]);
      else n_pass++;
      n_checks++;
      if (o_data[k] !== 32'h0) $display("FAIL reset_outs[%0d]: got %h want 0", k, o_data[k]);
      else n_pass++;
      n_checks++;
      if (o_last[k] !== 1'b0) $display("FAIL reset_last[%0d]: got %b want 0", k, o_last[k]);
      else n_pass++;
      n_checks++;
      if (c_ready[k] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", k, c_ready[k]);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic acc, em, have;
    logic [32:0] exp, got;
    logic [31:0] want [7];
    want = '{32'h11, 32'h22, 32'h33, 32'h11, 32'h22, 32'h33, 32'h11};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      c_valid[0] = (i < 7);
      o_ready[0] = 1'b1;
      rw[0]      = 1'b0;
      sample(0, acc, em, have, exp, got);
      if (i >= 1 && i <= 7) begin
        n_checks++;
        if (em !== 1'b1) $display("FAIL basic_valid[%0d]: got %b want 1", i, em);
        else n_pass++;
        n_checks++;
        if (got !== {(want[i-1] == 32'h33), want[i-1]})
          $display("FAIL basic_const[%0d]: got %h want %h", i, got, {(want[i-1] == 32'h33), want[i-1]});
        else n_pass++;
        n_checks++;
        if (!have || got !== exp) $display("FAIL basic_model[%0d]: got %h want %h", i, got, exp);
        else n_pass++;
      end else begin
        n_checks++;
        if (o_valid[0] !== 1'b0) $display("FAIL basic_idle[%0d]: got %b want 0", i, o_valid[0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc, em, have, seen;
    logic [32:0] exp, got, held;
    int nacc;
    seen = 1'b0;
    nacc = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      c_valid[0] = 1'b1;
      o_ready[0] = 1'b0;
      sample(0, acc, em, have, exp, got);
      if (acc) nacc++;
      n_checks++;
      if (o_valid[0] !== have) $display("FAIL bp_valid[%0d]: got %b want %b", i, o_valid[0], have);
      else n_pass++;
      if (i >= CAP) begin
        n_checks++;
        if (c_ready[0] !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, c_ready[0]);
        else n_pass++;
      end
      if (o_valid[0]) begin
        if (!seen) begin
          held = got;
          seen = 1'b1;
        end else begin
          n_checks++;
          if (got !== held) $display("FAIL bp_stable[%0d]: got %h want %h", i, got, held);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (nacc != CAP) $display("FAIL bp_accepted: got %0d want %0d", nacc, CAP);
    else n_pass++;
    n_checks++;
    if (q.size() == 0 || held !== q[0]) $display("FAIL bp_head: got %h want %h", held, (q.size() != 0) ? q[0] : 33'h0);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      c_valid[0] = (i < 5);
      o_ready[0] = 1'b1;
      sample(0, acc, em, have, exp, got);
      n_checks++;
      if (o_valid[0] !== have) $display("FAIL bp_release_valid[%0d]: got %b want %b", i, o_valid[0], have);
      else n_pass++;
      if (em) begin
        n_checks++;
        if (!have || got !== exp) $display("FAIL bp_release_data[%0d]: got %h want %h", i, got, exp);
        else n_pass++;
      end
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL bp_drain: got %0d left want 0", q.size());
    else n_pass++;
  endtask

  task automatic test_rewind();
    logic acc, em, have;
    logic [32:0] exp, got;
    logic [9:0] v_seq, r_seq;
    logic [31:0] want [5];
    int ne;
    v_seq = 10'b0001110110;
    r_seq = 10'b0000101001;
    want  = '{32'h11, 32'h22, 32'h11, 32'h11, 32'h22};
    ne    = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      c_valid[0] = v_seq[i];
      rw[0]      = r_seq[i];
      o_ready[0] = 1'b1;
      sample(0, acc, em, have, exp, got);
      if (em) begin
        if (ne < 5) begin
          n_checks++;
          if (got !== {1'b0, want[ne]}) $display("FAIL rewind_const[%0d]: got %h want %h", ne, got, {1'b0, want[ne]});
          else n_pass++;
        end
        n_checks++;
        if (!have || got !== exp) $display("FAIL rewind_model[%0d]: got %h want %h", ne, got, exp);
        else n_pass++;
        ne++;
      end
    end
    rw[0] = 1'b0;
    n_checks++;
    if (ne != 5) $display("FAIL rewind_count: got %0d want 5", ne);
    else n_pass++;
  endtask

  task automatic test_depth1();
    logic acc, em, have;
    logic [32:0] exp, got;
    int ne;
    ne = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      c_valid[1] = (i < 4);
      rw[1]      = (i == 2);
      o_ready[1] = 1'b1;
      sample(1, acc, em, have, exp, got);
      if (em) begin
        ne++;
        n_checks++;
        if (got !== 33'h1_DEADBEEF) $display("FAIL depth1_data[%0d]: got %h want 1deadbeef", ne, got);
        else n_pass++;
        n_checks++;
        if (!have || got !== exp) $display("FAIL depth1_model[%0d]: got %h want %h", ne, got, exp);
        else n_pass++;
      end
    end
    rw[1] = 1'b0;
    n_checks++;
    if (ne != 4) $display("FAIL depth1_count: got %0d want 4", ne);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic acc, em, have;
    logic [32:0] exp, got;
    int ne;
    ne = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      c_valid[0] = 1'b1;
      o_ready[0] = 1'b0;
      sample(0, acc, em, have, exp, got);
    end
    n_checks++;
    if (o_valid[0] !== 1'b1 || c_ready[0] !== 1'b0)
      $display("FAIL rmid_full: got valid %b ready %b want 1 0", o_valid[0], c_ready[0]);
    else n_pass++;
    #2;
    rst = 1'b0;
    c_valid[0] = 1'b0;
    #1;
    n_checks++;
    if (o_valid[0] !== 1'b0) $display("FAIL rmid_valid: got %b want 0", o_valid[0]);
    else n_pass++;
    n_checks++;
    if ({o_last[0], o_data[0]} !== 33'h0) $display("FAIL rmid_outs: got %h want 0", {o_last[0], o_data[0]});
    else n_pass++;
    q.delete();
    for (int k = 0; k < 3; k++) pos[k] = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      c_valid[0] = (i < 3);
      o_ready[0] = 1'b1;
      sample(0, acc, em, have, exp, got);
      n_checks++;
      if (o_valid[0] !== have) $display("FAIL rmid_after_valid[%0d]: got %b want %b", i, o_valid[0], have);
      else n_pass++;
      if (em) begin
        ne++;
        if (ne == 1) begin
          n_checks++;
          if (got !== {1'b0, 32'h11}) $display("FAIL rmid_first: got %h want 011", got);
          else n_pass++;
        end
        n_checks++;
        if (!have || got !== exp) $display("FAIL rmid_model[%0d]: got %h want %h", ne, got, exp);
        else n_pass++;
      end
    end
    n_checks++;
    if (ne != 3) $display("FAIL rmid_count: got %0d want 3", ne);
    else n_pass++;
  endtask

  task automatic test_random();
    logic acc, em, have, prev_stall;
    logic [32:0] exp, got, prev_got;
    int nacc, nem;
    nacc = 0;
    nem = 0;
    prev_stall = 1'b0;
    prev_got = '0;
    for (int i = 0; i < 10010; i++) begin
      @(negedge clk);
      c_valid[2] = (i < 10000) ? (($urandom & 1) != 0) : 1'b0;
      o_ready[2] = (i < 10000) ? (($urandom & 1) != 0) : 1'b1;
      rw[2]      = 1'b0;
      sample(2, acc, em, have, exp, got);
      if (acc) nacc++;
      n_checks++;
      if (o_valid[2] !== have) $display("FAIL rand_valid[%0d]: got %b want %b", i, o_valid[2], have);
      else n_pass++;
      if (em) begin
        nem++;
        n_checks++;
        if (!have || got !== exp) $display("FAIL rand_data[%0d]: got %h want %h", i, got, exp);
        else n_pass++;
      end
      if (prev_stall) begin
        n_checks++;
        if (got !== prev_got) $display("FAIL rand_stable[%0d]: got %h want %h", i, got, prev_got);
        else n_pass++;
      end
      prev_stall = o_valid[2] & ~o_ready[2];
      prev_got   = got;
    end
    n_checks++;
    if (nacc != nem || q.size() != 0)
      $display("FAIL rand_count: got %0d emitted want %0d accepted (%0d left)", nem, nacc, q.size());
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c_valid[k] = 1'b0;
      rw[k]      = 1'b0;
      o_ready[k] = 1'b0;
      pos[k]     = 0;
      for (int j = 0; j < 5; j++) tbl[k][j] = '0;
    end
    d = '{3, 1, 5};
    tbl[0][0] = 32'h11; tbl[0][1] = 32'h22; tbl[0][2] = 32'h33;
    tbl[1][0] = 32'hDEADBEEF;
    tbl[2][0] = 32'h11110000; tbl[2][1] = 32'h22220001; tbl[2][2] = 32'h33330002;
    tbl[2][3] = 32'h44440003; tbl[2][4] = 32'h55550004;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_rewind();
    test_depth1();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
